// File: rtl/adder_host_pkg.sv
// Shared constants and types for the adder_host initiator: command
// encodings, FSM states and the default baud divisor.
package adder_host_pkg;

  localparam logic [7:0] CMD_CLEAR = 8'h58;
  localparam logic [3:0] DIGIT_HI  = 4'h3;

  // 12 MHz system clock divided down to 115200 baud
  localparam int B115200 = 104;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return b[7:4] == DIGIT_HI;
  endfunction

  function automatic logic is_legal(input logic [7:0] b);
    return is_digit(b) || (b == CMD_CLEAR);
  endfunction

endpackage

// File: rtl/adder_host_model.sv
// Bit-exact model of the responder's 4-bit accumulator; also serves as the
// scoreboard in the responder's own bench.
module adder_model
  import adder_host_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       upd,
  input  logic       clr,
  input  logic [3:0] digit,
  output logic [7:0] expected,
  output logic [3:0] acc
);
  logic [3:0] a, b;
  logic       c;
  logic [4:0] sum;

  assign sum      = {1'b0, a} + {1'b0, b} + {4'b0, c};
  assign expected = {DIGIT_HI, b};
  assign acc      = b;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a <= '0;
      b <= '0;
      c <= 1'b0;
    end else if (upd) begin
      if (clr) begin
        a <= '0;
        b <= '0;
        c <= 1'b0;
      end else begin
        a      <= digit;
        {c, b} <= sum;
      end
    end
  end

endmodule

// File: rtl/adder_host_uart.sv
// 8N1 serial transmitter and receiver shared by the host and the responder.
// Both use a BAUD-cycle bit period and idle the line high.
module uart_tx #(
  parameter int BAUD = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);
  localparam int CW = $clog2(BAUD + 1);

  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    bits;
  logic [8:0]    sr;

  assign ready = !busy;

  // Start bit goes out on the edge that accepts start; the 9-bit shift
  // register then supplies the eight data bits followed by the stop bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx   <= 1'b1;
      busy <= 1'b0;
      cnt  <= '0;
      bits <= '0;
      sr   <= '0;
    end else if (!busy) begin
      if (start) begin
        sr   <= {1'b1, data};
        tx   <= 1'b0;
        busy <= 1'b1;
        cnt  <= '0;
        bits <= '0;
      end
    end else if (cnt == CW'(BAUD - 1)) begin
      cnt <= '0;
      if (bits == 4'd9) begin
        busy <= 1'b0;
      end else begin
        tx   <= sr[0];
        sr   <= {1'b1, sr[8:1]};
        bits <= bits + 4'd1;
      end
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

module uart_rx #(
  parameter int BAUD = 104
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       rcv,
  output logic [7:0] data
);
  localparam int CW = $clog2(BAUD + 1);

  logic          rx_meta, rx_sync;
  logic          busy;
  logic [CW-1:0] cnt;
  logic [3:0]    bits;
  logic [7:0]    sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Sample at mid-bit: half a period after the falling edge, then every
  // full period; a start bit that is high again at mid-bit is a glitch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= 1'b0;
      cnt  <= '0;
      bits <= '0;
      sr   <= '0;
      data <= '0;
      rcv  <= 1'b0;
    end else begin
      rcv <= 1'b0;
      if (!busy) begin
        if (!rx_sync) begin
          busy <= 1'b1;
          cnt  <= CW'(BAUD / 2);
          bits <= '0;
        end
      end else if (cnt == '0) begin
        cnt <= CW'(BAUD - 1);
        if (bits == 4'd0) begin
          if (rx_sync) busy <= 1'b0;
          else         bits <= 4'd1;
        end else if (bits <= 4'd8) begin
          sr   <= {rx_sync, sr[7:1]};
          bits <= bits + 4'd1;
        end else begin
          data <= sr;
          rcv  <= 1'b1;
          busy <= 1'b0;
        end
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_host.sv
// UART initiator for the serial accumulator responder: sends one command,
// waits for its reply and checks it against the local accumulator model.
module adder_host
  import adder_host_pkg::*;
#(
  parameter int BAUD    = B115200,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       tx,
  input  logic       rx,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_ok,
  output logic       timeout,
  output logic       cmd_err,
  output logic [3:0] model_acc
);
  localparam int TW = $clog2(TIMEOUT);

  state_t        state, state_next;
  logic [7:0]    cmd_q;
  logic [TW-1:0] tcnt;
  logic          tx_start, tx_ready;
  logic          rx_rcv;
  logic [7:0]    rx_byte;
  logic          rcv_hit, tmo_hit;
  logic          accept, legal;
  logic [7:0]    model_exp;

  assign cmd_ready = (state == IDLE);
  assign legal     = is_legal(cmd_data);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // A reply arriving on the last counted cycle beats the timeout.
  always_comb begin
    state_next = state;
    tx_start   = 1'b0;
    rcv_hit    = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: if (accept && legal) state_next = SEND;
      SEND: if (tx_ready) begin
        tx_start   = 1'b1;
        state_next = WAIT;
      end
      WAIT: if (rx_rcv) begin
        rcv_hit    = 1'b1;
        state_next = IDLE;
      end else if (tcnt == TW'(TIMEOUT - 1)) begin
        tmo_hit    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_q      <= '0;
      tcnt       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_ok    <= 1'b0;
      timeout    <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      resp_valid <= rcv_hit;
      resp_ok    <= rcv_hit && (rx_byte == model_exp);
      timeout    <= tmo_hit;
      cmd_err    <= accept && !legal;
      if (rcv_hit)         resp_data <= rx_byte;
      if (accept && legal) cmd_q     <= cmd_data;
      if (tx_start)            tcnt <= '0;
      else if (state == WAIT)  tcnt <= tcnt + 1'b1;
    end
  end

  uart_tx #(.BAUD(BAUD)) u_tx (
    .clk   (clk),
    .rstn  (rstn),
    .start (tx_start),
    .data  (cmd_q),
    .tx    (tx),
    .ready (tx_ready)
  );

  uart_rx #(.BAUD(BAUD)) u_rx (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .rcv  (rx_rcv),
    .data (rx_byte)
  );

  adder_model u_model (
    .clk      (clk),
    .rstn     (rstn),
    .upd      (rcv_hit || tmo_hit),
    .clr      (cmd_q == CMD_CLEAR),
    .digit    (cmd_q[3:0]),
    .expected (model_exp),
    .acc      (model_acc)
  );

endmodule

// File: tb/tb_adder_host.sv
// Bench for adder_host: plays the responder on rx and checks every host
// output against a plain-arithmetic accumulator model.
module tb_adder_host;
  localparam int BAUD    = 8;
  localparam int TIMEOUT = 400;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, tx, resp_valid, resp_ok, timeout, cmd_err;
  logic       rx = 1'b1;
  logic [7:0] resp_data;
  logic [3:0] model_acc;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tx_start_cyc = 0;
  int ref_a = 0, ref_b = 0, ref_c = 0;

  adder_host #(.BAUD(BAUD), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .tx         (tx),
    .rx         (rx),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ok    (resp_ok),
    .timeout    (timeout),
    .cmd_err    (cmd_err),
    .model_acc  (model_acc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed hang expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accumulator rules applied to the reference; returns the reply the
  // responder should send (its b before the update).
  function automatic logic [7:0] ref_apply(input logic [7:0] cmd);
    logic [7:0] reply;
    int sum;
    reply = 8'h30 + 8'(ref_b);
    if (cmd == 8'h58) begin
      ref_a = 0; ref_b = 0; ref_c = 0;
    end else begin
      sum   = ref_a + ref_b + ref_c;
      ref_b = sum % 16;
      ref_c = sum / 16;
      ref_a = cmd - 8'h30;
    end
    return reply;
  endfunction

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    check("cmd_ready_before_send", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_data  = b;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic capture_tx(output logic [7:0] b);
    bit seen = 0;
    b = '0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1;
    end
    check("tx_start_bit_seen", seen, 1);
    if (!seen) return;
    tx_start_cyc = cyc;
    repeat (BAUD / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BAUD) @(negedge clk);
      b[i] = tx;
    end
    repeat (BAUD) @(negedge clk);
    check("tx_stop_bit", tx, 1);
    repeat (BAUD / 2 + 1) @(negedge clk);
  endtask

  task automatic drive_rx(input logic [7:0] b);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic wait_resp(input logic [7:0] exp_data, input logic exp_ok,
                           input logic [3:0] exp_acc);
    bit seen = 0;
    for (int i = 0; i < 12 * BAUD + 20 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) seen = 1;
    end
    check("resp_valid_seen", seen, 1);
    if (!seen) return;
    check("resp_data", resp_data, exp_data);
    check("resp_ok", resp_ok, exp_ok);
    check("model_acc_after_reply", model_acc, exp_acc);
    check("no_timeout_with_resp", timeout, 0);
    @(negedge clk);
    check("resp_valid_one_cycle", resp_valid, 0);
    check("resp_data_held", resp_data, exp_data);
  endtask

  // Full exchange; a nonzero mask makes the responder send a wrong byte.
  task automatic do_txn(input logic [7:0] cmd, input logic [7:0] mask);
    logic [7:0] got, reply;
    send_cmd(cmd);
    capture_tx(got);
    check("tx_frame", got, cmd);
    reply = ref_apply(cmd) ^ mask;
    fork
      drive_rx(reply);
      wait_resp(reply, mask == 8'h00, 4'(ref_b));
    join
  endtask

  task automatic offer_illegal(input logic [7:0] b);
    logic [3:0] acc_before;
    acc_before = 4'(ref_b);
    send_cmd(b);
    @(negedge clk);
    check("cmd_err_pulse", cmd_err, 1);
    check("illegal_tx_idle", tx, 1);
    check("illegal_cmd_ready", cmd_ready, 1);
    check("illegal_no_resp", resp_valid, 0);
    @(negedge clk);
    check("cmd_err_one_cycle", cmd_err, 0);
    check("illegal_model_kept", model_acc, acc_before);
  endtask

  initial begin
    logic [7:0] got, b;
    int widx;
    bit seen, extra;

    repeat (3) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_tx", tx, 1);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_model_acc", model_acc, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", cmd_ready, 1);

    // directed sequence including the carry wrap and a clear
    do_txn(8'h35, 8'h00);
    do_txn(8'h33, 8'h00);
    do_txn(8'h39, 8'h00);
    do_txn(8'h3F, 8'h00);
    do_txn(8'h30, 8'h00);
    check("carry_after_wrap", ref_c, 1);
    do_txn(8'h58, 8'h00);
    check("model_acc_after_clear", model_acc, 0);
    do_txn(8'h37, 8'h00);

    offer_illegal(8'h41);

    // responder silent: rx stays high
    send_cmd(8'h32);
    capture_tx(got);
    check("timeout_tx_frame", got, 8'h32);
    void'(ref_apply(8'h32));
    seen = 0;
    extra = 0;
    for (int i = 0; i < TIMEOUT + 20 && !seen; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) extra = 1;
      if (timeout === 1'b1) seen = 1;
    end
    check("timeout_seen", seen, 1);
    check("timeout_latency", cyc - tx_start_cyc, TIMEOUT);
    check("timeout_no_resp", extra, 0);
    @(negedge clk);
    check("timeout_one_cycle", timeout, 0);
    check("timeout_back_idle", cmd_ready, 1);
    check("timeout_model_acc", model_acc, 4'(ref_b));

    // randomized exchanges, some with corrupted replies, plus illegal bytes
    for (int n = 0; n < 14; n++) begin
      widx = $urandom_range(0, 9);
      if (widx == 0) begin
        do_txn(8'h58, 8'h00);
      end else if (widx == 1) begin
        do b = 8'($urandom); while (b[7:4] == 4'h3 || b == 8'h58);
        offer_illegal(b);
      end else if (widx == 2) begin
        do_txn(8'h30 + 8'($urandom_range(0, 15)), 8'(1 << $urandom_range(0, 7)));
      end else begin
        do_txn(8'h30 + 8'($urandom_range(0, 15)), 8'h00);
      end
    end

    // reset while waiting for a reply
    send_cmd(8'h3A);
    capture_tx(got);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    check("midreset_model_acc", model_acc, 0);
    check("midreset_cmd_ready", cmd_ready, 1);
    check("midreset_tx", tx, 1);
    check("midreset_no_resp", resp_valid, 0);
    ref_a = 0; ref_b = 0; ref_c = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("after_reset_cmd_ready", cmd_ready, 1);
    extra = 0;
    fork
      drive_rx(8'h35);
      for (int i = 0; i < 10 * BAUD + 4; i++) begin
        @(negedge clk);
        if (resp_valid === 1'b1 || timeout === 1'b1 || cmd_err === 1'b1) extra = 1;
      end
    join
    check("stray_reply_ignored", extra, 0);
    check("stray_model_acc", model_acc, 0);
    do_txn(8'h34, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder_host.md
Name: adder_host

Overview:
- UART initiator for the 4-bit serial accumulator ("adder") responder. It is the other end of that protocol.
- Accepts command bytes from a local source and serialises them on tx. It then waits for the one-byte reply on rx.
- Checks each reply against an internal bit-exact model of the responder's accumulator.
- Used as an on-board self-test master and as a bench driver for the responder.

Parameters:
- BAUD, `B115200, baud divisor from baudgen.vh; passed to uart_tx/uart_rx.
- TIMEOUT, 4096, clk cycles allowed from the uart_tx start pulse to the reply's rcv pulse.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command byte offered
- cmd_data  in  8  command byte
- cmd_ready  out  1  host can accept a command
- tx  out  1  serial line to responder
- rx  in  1  serial line from responder
- resp_valid  out  1  one-cycle pulse: reply received
- resp_data  out  8  received reply byte, held until the next reply
- resp_ok  out  1  reply matched the model; qualified by resp_valid
- timeout  out  1  one-cycle pulse: no reply within TIMEOUT
- cmd_err  out  1  one-cycle pulse: illegal command dropped
- model_acc  out  4  current model accumulator (b), for LEDs

Behaviour:
- Reset (async, rstn=0), effective immediately, also mid-transfer:
  - state IDLE, model a=b=0 and c=0, all outputs 0 except cmd_ready.
  - cmd_ready=1 once rstn releases.
  - The uart_tx/uart_rx instances share rstn, so tx idles high.
- Command classes:
  - Digit: cmd_data[7:4]==4'h3 (0x30..0x3F).
  - Clear: cmd_data==8'h58 ('X').
  - Anything else is illegal.
- Handshake: transfer occurs on cycle with cmd_valid & cmd_ready. cmd_ready=1 only in IDLE.
- FSM:
  - IDLE:
    - Legal transfer: latch the byte, go to SEND.
    - Illegal transfer: cmd_err pulses next cycle, no transmission, stay IDLE.
  - SEND:
    - Wait for uart_tx ready=1, then assert start for exactly one cycle.
    - Clear the timeout counter and go to WAIT.
  - WAIT:
    - Counter increments each cycle.
    - On uart_rx rcv: capture resp_data and pulse resp_valid for one cycle.
      - resp_ok = (rx byte == {4'h3, b}), using b before update.
      - Update the model, then go to IDLE.
    - Counter reaches TIMEOUT-1 without rcv: pulse timeout, still update the model (the command was sent), go to IDLE.
- Model update. The reply always reports b before the update.
  - Digit d: a<=d; {c,b}<=a+b+c (5-bit sum, b wraps mod 16).
  - Clear: a<=0, b<=0, c<=0.
- rcv in IDLE or SEND (stray byte): ignored, no outputs change.
- rcv and timeout in the same cycle: rcv wins, no timeout pulse.
- Minimum latency, accept to resp_valid: 1 (to SEND) + tx frame + responder frame.
  - Nominally 2 byte-times plus a few cycles.
- resp_valid, timeout and cmd_err are mutually exclusive in any cycle.

Decomposition:
- Shared header (alongside baudgen.vh):
  - CMD_CLEAR = 8'h58
  - DIGIT_HI = 4'h3
  - FSM state encodings IDLE/SEND/WAIT
- Reuse the existing uart_tx and uart_rx; no new serial logic.
- One natural sub-module, adder_model:
  - holds a, b, c
  - inputs: upd strobe, clr, digit
  - outputs: expected reply and b
  - The responder testbench shares this sub-module as its scoreboard.

Test Plan:
- Reset, then send 0x35 → tx frame 0x35, reply 0x30, resp_ok=1; model a=5, b=0.
- Continue with 0x33, 0x39, 0x3F, 0x30:
  - Replies: 0x30, 0x35, 0x38, 0x31, all resp_ok=1.
  - Final model: b=1, c=1 (carry wrap).
- Send 0x58 after that sequence → reply 0x31 (old b), resp_ok=1; model_acc=0. Next 0x37 → reply 0x30.
- Offer 0x41 → cmd_err pulses one cycle, tx stays high, cmd_ready stays 1, model unchanged.
- Responder disconnected (rx held high), send 0x32:
  - Exactly TIMEOUT cycles after start, timeout pulses and FSM returns to IDLE.
  - model a=2, no resp_valid.
- Deassert rstn during WAIT:
  - Immediately cmd_ready=1 (after release), model_acc=0, no pulses.
  - A later reply byte on rx is ignored.
